pll_lock_sequencer: RTL and testbench

//  Controller for the core PLL's rst/locked interface. Runs on the free-running 74.25 MHz reference clock.

---
 rtl/pll_lock_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, debounces lock, retries, and flags a sticky fault.
// Optional auto-restart from FAULT after a backoff: define PLL_LOCK_SEQ_FAULT_RECOVER_EN.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 74250,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7,
  parameter int FAULT_BACKOFF  = 742500
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic       fault,
  output logic [3:0] retry_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(LOCK_TIMEOUT, STABLE_CYCLES), max2(PLL_RST_CYCLES, FAULT_BACKOFF));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);
`ifdef PLL_LOCK_SEQ_FAULT_RECOVER_EN
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(FAULT_BACKOFF - 1);
`endif

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic             sync_reg [SYNC_STAGES];
  logic             locked_s;

  // Metastability chain for the asynchronous lock input.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_74a) begin
          if (!reset_n) sync_reg[gi] <= 1'b0;
          else          sync_reg[gi] <= pll_locked;
        end
      end else begin : g_rest
        always_ff @(posedge clk_74a) begin
          if (!reset_n) sync_reg[gi] <= 1'b0;
          else          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign locked_s = sync_reg[SYNC_STAGES-1];
  assign cnt_inc  = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state_reg    <= S_PLL_RST;
      cnt_reg      <= '0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= 4'd0;
    end else begin
      lock_lost <= 1'b0;
      case (state_reg)
        S_PLL_RST: begin
          pll_rst <= 1'b1;
          if (cnt_reg == RST_LAST) begin
            state_reg <= S_WAIT_LOCK;
            cnt_reg   <= '0;
            pll_rst   <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        // A lock arriving on the timeout cycle wins over the retry.
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_reg <= S_STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_reg <= '0;
            pll_rst <= 1'b1;
            if (retry_count == RETRY_LIMIT) begin
              state_reg <= S_FAULT;
              fault     <= 1'b1;
            end else begin
              state_reg   <= S_PLL_RST;
              retry_count <= retry_count + 4'd1;
            end
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        S_STABLE: begin
          if (!locked_s) begin
            state_reg <= S_WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg    <= S_RUN;
            cnt_reg      <= '0;
            core_reset_n <= 1'b1;
            ready        <= 1'b1;
            retry_count  <= 4'd0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state_reg    <= S_PLL_RST;
            cnt_reg      <= '0;
            lock_lost    <= 1'b1;
            core_reset_n <= 1'b0;
            ready        <= 1'b0;
            pll_rst      <= 1'b1;
          end
        end

        S_FAULT: begin
          pll_rst      <= 1'b1;
          core_reset_n <= 1'b0;
          fault        <= 1'b1;
`ifdef PLL_LOCK_SEQ_FAULT_RECOVER_EN
          if (cnt_reg == BACKOFF_LAST) begin
            state_reg   <= S_PLL_RST;
            cnt_reg     <= '0;
            fault       <= 1'b0;
            retry_count <= 4'd0;
          end else begin
            cnt_reg <= cnt_inc;
          end
`endif
        end

        default: begin
          state_reg    <= S_PLL_RST;
          cnt_reg      <= '0;
          pll_rst      <= 1'b1;
          core_reset_n <= 1'b0;
          ready        <= 1'b0;
          fault        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
// Expected cycle counts are hand-derived; build with PLL_LOCK_SEQ_FAULT_RECOVER_EN to cover auto-restart.
module tb_pll_lock_sequencer;

  logic       clk_74a = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       core_reset_n;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [3:0] retry_count;

  int checks = 0;
  int errors = 0;
  int n;
  int hi;
  int ll;
  int seen;

  always #5 clk_74a = ~clk_74a;

  pll_lock_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .FAULT_BACKOFF (64)
  ) dut (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .core_reset_n(core_reset_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .fault       (fault),
    .retry_count (retry_count)
  );

  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("tb: %s observed=%0d expected=%0d", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pll_rst"},      32'(pll_rst),      1);
    check({tag, "_core_reset_n"}, 32'(core_reset_n), 0);
    check({tag, "_ready"},        32'(ready),        0);
    check({tag, "_lock_lost"},    32'(lock_lost),    0);
    check({tag, "_fault"},        32'(fault),        0);
    check({tag, "_retry_count"},  32'(retry_count),  0);
  endtask

  // Counts pll_rst-high samples starting with the current one; also tallies lock_lost.
  task automatic measure_pulse(output int hi_n, output int ll_n);
    hi_n = 0;
    ll_n = 0;
    if (pll_rst)   hi_n++;
    if (lock_lost) ll_n++;
    for (int i = 0; i < 20 && pll_rst; i++) begin
      tick();
      if (pll_rst)   hi_n++;
      if (lock_lost) ll_n++;
    end
  endtask

  task automatic wait_rst_rise(output int cyc);
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      cyc++;
      if (pll_rst) break;
    end
  endtask

  // Edge count includes the first edge that samples pll_locked high.
  task automatic wait_run(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cyc++;
      if (core_reset_n) break;
    end
  endtask

  task automatic wait_ready_low(output int cyc);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cyc++;
      if (!ready) break;
    end
  endtask

  task automatic wait_fault(output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cyc++;
      if (fault) break;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    repeat (3) tick();
    check_reset("reset");

    // Scenario 1: power-up sequence to RUN.
    reset_n = 1'b1;
    measure_pulse(hi, ll);
    check("s1_prst_len", hi, 4);
    repeat (5) tick();
    pll_locked = 1'b1;
    wait_run(n);
    check("s1_lock_to_run", n, 11);
    check("s1_ready", 32'(ready), 1);
    check("s1_retry", 32'(retry_count), 0);
    check("s1_fault", 32'(fault), 0);
    check("s1_prst_low", 32'(pll_rst), 0);

    // Scenario 4: loss of lock in RUN, one timeout retry, re-lock clears retry_count.
    pll_locked = 1'b0;
    wait_ready_low(n);
    check("s4_loss_latency", n, 3);
    check("s4_lock_lost_now", 32'(lock_lost), 1);
    check("s4_core_reset_n", 32'(core_reset_n), 0);
    measure_pulse(hi, ll);
    check("s4_prst_len", hi, 4);
    check("s4_lock_lost_cycles", ll, 1);
    wait_rst_rise(n);
    check("s4_timeout", n, 32);
    check("s4_retry_1", 32'(retry_count), 1);
    measure_pulse(hi, ll);
    check("s4_retry_prst_len", hi, 4);
    pll_locked = 1'b1;
    wait_run(n);
    check("s4_relock_to_run", n, 11);
    check("s4_retry_cleared", 32'(retry_count), 0);

    // Scenario 2: one-cycle lock glitch seen by the FSM at STABLE cnt=5.
    pll_locked = 1'b0;
    wait_ready_low(n);
    check("s2_loss_latency", n, 3);
    measure_pulse(hi, ll);
    check("s2_prst_len", hi, 4);
    pll_locked = 1'b1;
    n    = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (pll_rst) seen++;
      if (n == 6) pll_locked = 1'b0;
      if (n == 7) pll_locked = 1'b1;
      if (core_reset_n) break;
    end
    check("s2_rerise_to_run", n - 7, 11);
    check("s2_no_prst", seen, 0);
    check("s2_retry", 32'(retry_count), 0);

    // Scenario 5a: reset mid-STABLE.
    pll_locked = 1'b0;
    wait_ready_low(n);
    measure_pulse(hi, ll);
    check("s5a_prst_len", hi, 4);
    pll_locked = 1'b1;
    repeat (6) tick();
    check("s5a_pre_core", 32'(core_reset_n), 0);
    check("s5a_pre_prst", 32'(pll_rst), 0);
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    tick();
    check_reset("s5a");
    reset_n = 1'b1;
    measure_pulse(hi, ll);
    check("s5a_restart_prst_len", hi, 4);

    // Scenario 3: no lock ever; two retries then FAULT.
    wait_rst_rise(n);
    check("s3_timeout_1", n, 32);
    check("s3_retry_1", 32'(retry_count), 1);
    measure_pulse(hi, ll);
    check("s3_prst_len_1", hi, 4);
    wait_rst_rise(n);
    check("s3_timeout_2", n, 32);
    check("s3_retry_2", 32'(retry_count), 2);
    measure_pulse(hi, ll);
    check("s3_prst_len_2", hi, 4);
    wait_fault(n);
    check("s3_timeout_3", n, 32);
    check("s3_fault_prst", 32'(pll_rst), 1);
    check("s3_fault_core", 32'(core_reset_n), 0);
    check("s3_fault_retry", 32'(retry_count), 2);

`ifdef PLL_LOCK_SEQ_FAULT_RECOVER_EN
    // Scenario 6: backoff expiry restarts the sequence.
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (!fault) break;
    end
    check("s6_backoff", n, 64);
    check("s6_retry_cleared", 32'(retry_count), 0);
    measure_pulse(hi, ll);
    check("s6_prst_len", hi, 4);
    wait_fault(n);
    check("s6_refault", 32'(fault), 1);
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fault && pll_rst && !core_reset_n) seen++;
    end
    check("s3_fault_sticky", seen, 1000);
`endif

    // Scenario 5b: reset mid-FAULT, then a clean power-up.
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check_reset("s5b");
    reset_n = 1'b1;
    measure_pulse(hi, ll);
    check("s5b_restart_prst_len", hi, 4);
    pll_locked = 1'b1;
    wait_run(n);
    check("s5b_lock_to_run", n, 11);
    check("s5b_ready", 32'(ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
